// File: rtl/gate_checker.sv
// Exhaustive three-input gate tester: steps {A,B,C} through 0..7, compares F
// against !C & (!A | B) after SETTLE cycles per vector, and reports the result.
module gate_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic       F,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_COUNT,
  output logic [2:0] FIRST_FAIL,
  output logic       FAIL_VALID
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [3:0] ERR_MAX = 4'd8;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nx;
  logic [2:0]       idx, idx_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       abc_nx;
  logic             busy_nx, done_nx, pass_nx, fv_nx;
  logic [3:0]       err_nx, err_upd;
  logic [2:0]       ff_nx;
  logic             expected_c, mismatch_c;

  // idx is {A,B,C}, so A = idx[2] and C = idx[0]
  assign expected_c = ~idx[0] & (~idx[2] | idx[1]);
  assign mismatch_c = (F != expected_c);

  // Next-state and registered-output logic
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    abc_nx   = 3'b000;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    pass_nx  = PASS;
    err_nx   = ERR_COUNT;
    err_upd  = ERR_COUNT;
    ff_nx    = FIRST_FAIL;
    fv_nx    = FAIL_VALID;
    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          state_nx = RUN;
          idx_nx   = 3'd0;
          cnt_nx   = '0;
          err_nx   = 4'd0;
          ff_nx    = 3'd0;
          fv_nx    = 1'b0;
          pass_nx  = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_nx = IDLE;
          pass_nx  = 1'b0;
        end else begin
          busy_nx = 1'b1;
          abc_nx  = idx;
          if (cnt == SETTLE_LAST) begin
            if (mismatch_c) begin
              if (ERR_COUNT != ERR_MAX) err_upd = ERR_COUNT + 4'd1;
              if (!FAIL_VALID) begin
                ff_nx = idx;
                fv_nx = 1'b1;
              end
            end
            err_nx = err_upd;
            cnt_nx = '0;
            if (idx == 3'd7) begin
              state_nx = FIN;
              pass_nx  = (err_upd == 4'd0);
              abc_nx   = 3'b000;
              done_nx  = 1'b1;
            end else begin
              idx_nx = idx + 3'd1;
              abc_nx = idx + 3'd1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      FIN: begin
        state_nx = IDLE;
        if (ABORT) pass_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= '0;
      A          <= 1'b0;
      B          <= 1'b0;
      C          <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_COUNT  <= 4'd0;
      FIRST_FAIL <= 3'd0;
      FAIL_VALID <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      {A, B, C}  <= abc_nx;
      BUSY       <= busy_nx;
      DONE       <= done_nx;
      PASS       <= pass_nx;
      ERR_COUNT  <= err_nx;
      FIRST_FAIL <= ff_nx;
      FAIL_VALID <= fv_nx;
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: three instances with SETTLE 1, 2 and 3,
// table-driven runs, hand-written corner sequences and randomized runs.
module tb_gate_checker;

  logic       clk;
  logic       rst_n;
  logic       start      [3];
  logic       abort      [3];
  logic       f          [3];
  logic       a          [3];
  logic       b          [3];
  logic       c          [3];
  logic       busy       [3];
  logic       done       [3];
  logic       pass       [3];
  logic [3:0] err_count  [3];
  logic [2:0] first_fail [3];
  logic       fail_valid [3];

  int checks;
  int errors;
  int cur_dut;
  int cur_cyc;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gate_checker #(.SETTLE(g + 1)) u_dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .START      (start[g]),
      .ABORT      (abort[g]),
      .F          (f[g]),
      .A          (a[g]),
      .B          (b[g]),
      .C          (c[g]),
      .BUSY       (busy[g]),
      .DONE       (done[g]),
      .PASS       (pass[g]),
      .ERR_COUNT  (err_count[g]),
      .FIRST_FAIL (first_fail[g]),
      .FAIL_VALID (fail_valid[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dut;
    int mode;        // 0 correct gate, 1 stuck at 0, 2 stuck at 1, 3 random F
    int abort_edge;  // edge index after accept carrying ABORT, -1 for none
    bit hold;        // keep START high through the run
    bit chk;         // compare the final fields below
    int err;
    int ff;
    bit fv;
    bit pass;
  } vec_t;

  vec_t tbl [10];

  // The gate truth table: output is 1 only for {A,B,C} = 0, 2, 6
  function automatic bit gate_ref(input int k);
    return (k == 0) || (k == 2) || (k == 6);
  endfunction

  // F off the compare edges is random; it must never matter
  function automatic bit f_pick(input int mode, input bit cmp, input int k);
    if (!cmp || mode == 3) return 1'($urandom);
    case (mode)
      0:       return gate_ref(k);
      1:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc%0d: got %0d expected %0d", name, cur_dut, cur_cyc, act, exp);
    end
  endtask

  task automatic check_out(input int d, input int bz, input int dn, input int abc,
                           input int ps, input int er, input int ff, input int fv);
    cur_dut = d;
    chk("busy", int'(busy[d]), bz);
    chk("done", int'(done[d]), dn);
    chk("abc", int'({a[d], b[d], c[d]}), abc);
    chk("pass", int'(pass[d]), ps);
    chk("err_count", int'(err_count[d]), er);
    chk("first_fail", int'(first_fail[d]), ff);
    chk("fail_valid", int'(fail_valid[d]), fv);
  endtask

  // One run from IDLE; checks every cycle against a per-edge model.
  // Cycle j begins at edge j after the accept edge (cycle 0 begins at accept).
  task automatic run_one(input int d, input int mode, input int abort_edge, input bit hold);
    int s, n, ne, fst, k;
    bit fv, aborted, fb, cmp;
    s = d + 1;
    n = 8 * s;
    ne = 0;
    fst = 0;
    fv = 1'b0;
    aborted = 1'b0;
    start[d] = 1'b1;
    abort[d] = 1'b0;
    f[d] = 1'($urandom);
    @(posedge clk);
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge clk);
      cur_cyc = j;
      if (!hold) start[d] = 1'b0;
      abort[d] = 1'b0;
      if (aborted) begin
        check_out(d, 0, 0, 0, 0, ne, fst, int'(fv));
        @(negedge clk);
        cur_cyc = j + 1;
        check_out(d, 0, 0, 0, 0, ne, fst, int'(fv));
        break;
      end
      if (j < n)       check_out(d, 1, 0, j / s, 0, ne, fst, int'(fv));
      else if (j == n) check_out(d, 1, 1, 0, int'(ne == 0), ne, fst, int'(fv));
      else             check_out(d, 0, 0, 0, int'(ne == 0), ne, fst, int'(fv));
      if (j <= n) begin
        cmp = (((j + 1) % s) == 0) && (j + 1 <= n);
        k = (j + 1) / s - 1;
        fb = f_pick(mode, cmp, k);
        f[d] = fb;
        if (abort_edge == j + 1) begin
          abort[d] = 1'b1;
          aborted = 1'b1;
        end else if (cmp && (fb != gate_ref(k))) begin
          if (!fv) begin
            fv = 1'b1;
            fst = k;
          end
          ne++;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d, ab;
    checks = 0;
    errors = 0;
    cur_cyc = -1;
    tbl[0] = '{0, 0, -1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{0, 1, -1, 1'b0, 1'b1, 3, 0, 1'b1, 1'b0};
    tbl[2] = '{1, 2, -1, 1'b0, 1'b1, 5, 1, 1'b1, 1'b0};
    tbl[3] = '{2, 1, -1, 1'b1, 1'b1, 3, 0, 1'b1, 1'b0};
    tbl[4] = '{2, 0, -1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1};
    tbl[5] = '{2, 0, -1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1};
    tbl[6] = '{0, 1,  5, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0};
    tbl[7] = '{1, 2,  8, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0};
    tbl[8] = '{0, 0,  9, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
    tbl[9] = '{1, 3, -1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      f[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < 3; i++) check_out(i, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].dut, tbl[i].mode, tbl[i].abort_edge, tbl[i].hold);
      if (tbl[i].chk) begin
        cur_cyc = -2;
        chk("final_err", int'(err_count[tbl[i].dut]), tbl[i].err);
        chk("final_ff", int'(first_fail[tbl[i].dut]), tbl[i].ff);
        chk("final_fv", int'(fail_valid[tbl[i].dut]), int'(tbl[i].fv));
        chk("final_pass", int'(pass[tbl[i].dut]), int'(tbl[i].pass));
      end
    end

    // START with ABORT, then ABORT alone, in IDLE: nothing changes
    run_one(0, 0, -1, 1'b0);
    cur_cyc = -3;
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check_out(0, 0, 0, 0, 1, 0, 0, 0);
    abort[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort[0] = 1'b0;
    check_out(0, 0, 0, 0, 1, 0, 0, 0);

    // Asynchronous reset at index 5, then a clean run
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    f[0] = 1'b1;
    repeat (5) @(negedge clk);
    cur_cyc = -4;
    chk("abc_before_reset", int'({a[0], b[0], c[0]}), 5);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_out(i, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_out(0, 0, 0, 0, 0, 0, 0, 0);
    run_one(0, 0, -1, 1'b0);
    cur_cyc = -5;
    chk("pass_after_reset", int'(pass[0]), 1);

    // Randomized runs against the model
    for (int r = 0; r < 12; r++) begin
      d = int'($urandom_range(0, 2));
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 8 * (d + 1) + 1));
      run_one(d, int'($urandom_range(0, 3)), ab, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, the number of clock cycles each test vector is held on A/B/C before F is sampled (legal range 1..15).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port RST_N, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port START, input, 1 bit, a request to begin a run; it is sampled only in IDLE.
REQ-005 The block SHALL have port ABORT, input, 1 bit, which synchronously terminates a run in progress.
REQ-006 The block SHALL have port F, input, 1 bit, the response of the gate under test.
REQ-007 The block SHALL have ports A, B and C, outputs, 1 bit each, the stimulus driven to the gate under test.
REQ-008 The block SHALL have port BUSY, output, 1 bit, high while a run is in progress.
REQ-009 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse marking run completion.
REQ-010 The block SHALL have port PASS, output, 1 bit, meaning the last completed run had zero mismatches.
REQ-011 The block SHALL have port ERR_COUNT, output, 4 bits, the number of mismatching vectors in the current or last run.
REQ-012 The block SHALL have port FIRST_FAIL, output, 3 bits, the index {A,B,C} of the first mismatching vector.
REQ-013 The block SHALL have port FAIL_VALID, output, 1 bit, meaning FIRST_FAIL holds a captured index.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, RUN and FIN, with registered outputs.
REQ-015 In IDLE, {A,B,C} SHALL be 3'b000 and BUSY SHALL be 0; PASS, ERR_COUNT, FIRST_FAIL and FAIL_VALID SHALL hold their values.
REQ-016 On a rising edge in IDLE with START=1: vector index←0, settle counter←0, ERR_COUNT←0, FAIL_VALID←0, FIRST_FAIL←0, PASS←0, and the state SHALL go to RUN.
REQ-017 In RUN, {A,B,C} SHALL equal the 3-bit vector index (A is the MSB), BUSY SHALL be 1, and index order SHALL be 0,1,...,7.
REQ-018 Each vector SHALL be held for exactly SETTLE cycles; on the edge ending its SETTLE-th cycle, F SHALL be compared with expected = !C & (!A | B).
REQ-019 Expected F SHALL be 1 only for indices 0, 2 and 6.
REQ-020 On each mismatch, ERR_COUNT SHALL increment by 1 (maximum 8, no wrap); if FAIL_VALID=0, FIRST_FAIL←index and FAIL_VALID←1.
REQ-021 After a compare at index<7: index←index+1 and settle counter←0.
REQ-022 After the compare at index 7, the state SHALL go to FIN, and the index SHALL NOT wrap.
REQ-023 The compare at index 7 SHALL be included in ERR_COUNT before PASS is evaluated.
REQ-024 In FIN, DONE SHALL be 1 for exactly one cycle, BUSY SHALL be 1, and {A,B,C} SHALL be 3'b000.
REQ-025 On the FIN entry edge, PASS SHALL be set to (final ERR_COUNT==0); the state SHALL then go to IDLE on the next edge.
REQ-026 Latency SHALL be fixed: DONE is high in the cycle beginning 8*SETTLE edges after the START-accept edge.
REQ-027 START SHALL be ignored in RUN and FIN; if START is held high, a new run SHALL be accepted on the first edge in IDLE.
REQ-028 ABORT=1 in RUN or FIN SHALL force IDLE on that edge, with no DONE pulse and PASS=0; ERR_COUNT, FIRST_FAIL and FAIL_VALID SHALL retain partial results.
REQ-029 ABORT SHALL have priority over a compare on the same edge, so that compare is discarded.
REQ-030 ABORT in IDLE SHALL have no effect; START and ABORT both high in IDLE SHALL leave the block in IDLE.
REQ-031 F SHALL be sampled only on compare edges; F values at all other times SHALL have no effect.

Reset
REQ-032 RST_N=0 SHALL immediately, without a clock, force IDLE and drive A, B, C, BUSY, DONE, PASS, FAIL_VALID=0, ERR_COUNT=4'd0 and FIRST_FAIL=3'd0.
REQ-033 Reset asserted mid-run SHALL discard the run with no DONE pulse.
REQ-034 After RST_N deasserts, the first START SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-035 F driven by a correct gate, SETTLE=1, one-cycle START -> A/B/C step 000..111 one per cycle; DONE pulses 8 cycles after accept; PASS=1, ERR_COUNT=0, FAIL_VALID=0.
REQ-036 F stuck at 0, SETTLE=1 -> ERR_COUNT=3, FIRST_FAIL=3'd0, FAIL_VALID=1, PASS=0.
REQ-037 F stuck at 1, SETTLE=2 -> each vector held 2 cycles; DONE pulses 16 cycles after accept; ERR_COUNT=5, FIRST_FAIL=3'd1, PASS=0.
REQ-038 SETTLE=3, correct gate, START held high continuously -> DONE pulses 24 cycles after accept; IDLE lasts one cycle; the second run starts with ERR_COUNT cleared.
REQ-039 F stuck at 0, ABORT pulsed while index=4 -> IDLE on that edge; no DONE; PASS=0; ERR_COUNT=2 (indices 0 and 2); FIRST_FAIL=0.
REQ-040 RST_N pulsed low at index 5 without a clock edge -> all outputs 0 immediately; a later START runs a full clean pass with PASS=1.
